// File: rtl/scsi_initiator_if.sv
// Bus bundle between the SCSI initiator, the host register file and the CD target.
// master = initiator side, slave = host/target side.
interface scsi_initiator_if;
  // host command side
  logic [95:0] CMD_BYTES;
  logic [3:0]  CMD_LEN;
  logic        START;
  logic        BUS_RST;
  logic        BUSY;
  logic        DONE;
  logic        TIMEOUT;
  logic [7:0]  STATUS;
  logic [7:0]  MESSAGE;
  // host data streams
  logic [7:0]  DIN_DATA;
  logic        DIN_VALID;
  logic        DIN_READY;
  logic [7:0]  DOUT_DATA;
  logic        DOUT_VALID;
  logic        DOUT_READY;
  // SCSI bus, active-low control
  logic [7:0]  DBI;
  logic [7:0]  DBO;
  logic        SEL_N;
  logic        ACK_N;
  logic        RST_N;
  logic        BSY_N;
  logic        REQ_N;
  logic        MSG_N;
  logic        CD_N;
  logic        IO_N;

  modport master (
    input  CMD_BYTES, CMD_LEN, START, BUS_RST, DIN_READY, DOUT_DATA, DOUT_VALID,
           DBI, BSY_N, REQ_N, MSG_N, CD_N, IO_N,
    output BUSY, DONE, TIMEOUT, STATUS, MESSAGE, DIN_DATA, DIN_VALID, DOUT_READY,
           DBO, SEL_N, ACK_N, RST_N
  );

  modport slave (
    output CMD_BYTES, CMD_LEN, START, BUS_RST, DIN_READY, DOUT_DATA, DOUT_VALID,
           DBI, BSY_N, REQ_N, MSG_N, CD_N, IO_N,
    input  BUSY, DONE, TIMEOUT, STATUS, MESSAGE, DIN_DATA, DIN_VALID, DOUT_READY,
           DBO, SEL_N, ACK_N, RST_N
  );
endinterface

// File: rtl/scsi_initiator.sv
// Host-side SCSI initiator: selects the target, sends the CDB, then services
// DATA IN/OUT, STATUS and MESSAGE IN phases until the target goes bus free.
module scsi_initiator #(
  parameter int SEL_TIMEOUT = 10740,
  parameter int ACK_SETTLE  = 4,
  parameter int RST_CYCLES  = 1075
) (
  input  logic              CLK,
  input  logic              RESET,
  scsi_initiator_if.master  bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEL       = 3'd1;
  localparam logic [2:0] S_WAIT_REQ  = 3'd2;
  localparam logic [2:0] S_DOUT_WAIT = 3'd3;
  localparam logic [2:0] S_DIN_HOLD  = 3'd4;
  localparam logic [2:0] S_SETUP     = 3'd5;
  localparam logic [2:0] S_ACK       = 3'd6;

  // {MSG_N,CD_N,IO_N} phase codes (active-low lines)
  localparam logic [2:0] PH_CMD  = 3'b101;
  localparam logic [2:0] PH_DOUT = 3'b111;
  localparam logic [2:0] PH_DIN  = 3'b110;
  localparam logic [2:0] PH_STAT = 3'b100;
  localparam logic [2:0] PH_MSGI = 3'b000;

  localparam logic [13:0] SEL_LAST    = 14'(SEL_TIMEOUT - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'(ACK_SETTLE - 1);
  localparam logic [10:0] RST_LAST    = 11'(RST_CYCLES - 1);
  localparam logic [3:0]  IDX_MAX     = 4'd12;

  logic [2:0]        state_q, state_d;
  logic [11:0][7:0]  cdb_q, cdb_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        idx_q, idx_d;
  logic [13:0]       sel_cnt_q, sel_cnt_d;
  logic [3:0]        settle_q, settle_d;
  logic [10:0]       rst_cnt_q, rst_cnt_d;
  logic              sel_n_q, sel_n_d;
  logic              ack_n_q, ack_n_d;
  logic              rst_n_q, rst_n_d;
  logic [7:0]        dbo_q, dbo_d;
  logic [7:0]        status_q, status_d;
  logic [7:0]        message_q, message_d;
  logic [7:0]        din_data_q, din_data_d;
  logic              din_valid_q, din_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              dout_ready_q, dout_ready_d;

  logic [2:0] phase;
  assign phase = {bus.MSG_N, bus.CD_N, bus.IO_N};

  // Next-state logic: bus-reset counter, then either bus-reset abort or the phase FSM
  always_comb begin
    state_d      = state_q;
    cdb_d        = cdb_q;
    len_d        = len_q;
    idx_d        = idx_q;
    sel_cnt_d    = sel_cnt_q;
    settle_d     = settle_q;
    rst_cnt_d    = rst_cnt_q;
    sel_n_d      = sel_n_q;
    ack_n_d      = ack_n_q;
    rst_n_d      = rst_n_q;
    dbo_d        = dbo_q;
    status_d     = status_q;
    message_d    = message_q;
    din_data_d   = din_data_q;
    din_valid_d  = din_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    dout_ready_d = 1'b0;

    // RST_N low phase: counter loaded with RST_CYCLES-1 so the line stays low RST_CYCLES cycles
    if (!rst_n_q) begin
      if (rst_cnt_q == 11'd0) rst_n_d = 1'b1;
      else                    rst_cnt_d = rst_cnt_q - 11'd1;
    end

    if (bus.BUS_RST) begin
      rst_n_d     = 1'b0;
      rst_cnt_d   = RST_LAST;
      sel_n_d     = 1'b1;
      ack_n_d     = 1'b1;
      din_valid_d = 1'b0;
      busy_d      = 1'b0;
      state_d     = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.START && rst_n_q) begin
            cdb_d     = bus.CMD_BYTES;
            len_d     = bus.CMD_LEN;
            idx_d     = 4'd0;
            sel_cnt_d = 14'd0;
            busy_d    = 1'b1;
            sel_n_d   = 1'b0;
            state_d   = S_SEL;
          end
        end
        S_SEL: begin
          if (!bus.BSY_N) begin
            sel_n_d = 1'b1;
            state_d = S_WAIT_REQ;
          end else if (sel_cnt_q == SEL_LAST) begin
            sel_n_d   = 1'b1;
            timeout_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
          end else begin
            sel_cnt_d = sel_cnt_q + 14'd1;
          end
        end
        S_WAIT_REQ: begin
          if (bus.BSY_N) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (!bus.REQ_N) begin
            case (phase)
              PH_CMD: begin
                // bytes past CMD_LEN (or past the 12-byte buffer) go out as 0x00
                dbo_d    = ((idx_q < len_q) && (idx_q < IDX_MAX)) ? cdb_q[idx_q] : 8'h00;
                if (idx_q != IDX_MAX) idx_d = idx_q + 4'd1;
                settle_d = 4'd0;
                state_d  = S_SETUP;
              end
              PH_DOUT: state_d = S_DOUT_WAIT;
              PH_DIN: begin
                din_data_d  = bus.DBI;
                din_valid_d = 1'b1;
                state_d     = S_DIN_HOLD;
              end
              PH_STAT: begin
                status_d = bus.DBI;
                state_d  = S_ACK;
              end
              PH_MSGI: begin
                message_d = bus.DBI;
                state_d   = S_ACK;
              end
              default: begin
                // unknown phase: hand the target a null byte and move on
                dbo_d    = 8'h00;
                settle_d = 4'd0;
                state_d  = S_SETUP;
              end
            endcase
          end
        end
        S_DOUT_WAIT: begin
          if (bus.DOUT_VALID) begin
            dbo_d        = bus.DOUT_DATA;
            dout_ready_d = 1'b1;
            settle_d     = 4'd0;
            state_d      = S_SETUP;
          end
        end
        S_DIN_HOLD: begin
          if (bus.DIN_READY) begin
            din_valid_d = 1'b0;
            state_d     = S_ACK;
          end
        end
        S_SETUP: begin
          if (settle_q == SETTLE_LAST) state_d  = S_ACK;
          else                         settle_d = settle_q + 4'd1;
        end
        S_ACK: begin
          // ACK_N only falls against an asserted REQ_N and rises once REQ_N is released
          if (ack_n_q && !bus.REQ_N) begin
            ack_n_d = 1'b0;
          end else if (!ack_n_q && bus.REQ_N) begin
            ack_n_d = 1'b1;
            state_d = S_WAIT_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      cdb_q        <= '0;
      len_q        <= 4'd0;
      idx_q        <= 4'd0;
      sel_cnt_q    <= 14'd0;
      settle_q     <= 4'd0;
      rst_cnt_q    <= 11'd0;
      sel_n_q      <= 1'b1;
      ack_n_q      <= 1'b1;
      rst_n_q      <= 1'b1;
      dbo_q        <= 8'h00;
      status_q     <= 8'h00;
      message_q    <= 8'h00;
      din_data_q   <= 8'h00;
      din_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      dout_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cdb_q        <= cdb_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      sel_cnt_q    <= sel_cnt_d;
      settle_q     <= settle_d;
      rst_cnt_q    <= rst_cnt_d;
      sel_n_q      <= sel_n_d;
      ack_n_q      <= ack_n_d;
      rst_n_q      <= rst_n_d;
      dbo_q        <= dbo_d;
      status_q     <= status_d;
      message_q    <= message_d;
      din_data_q   <= din_data_d;
      din_valid_q  <= din_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      dout_ready_q <= dout_ready_d;
    end
  end

  assign bus.SEL_N      = sel_n_q;
  assign bus.ACK_N      = ack_n_q;
  assign bus.RST_N      = rst_n_q;
  assign bus.DBO        = dbo_q;
  assign bus.STATUS     = status_q;
  assign bus.MESSAGE    = message_q;
  assign bus.DIN_DATA   = din_data_q;
  assign bus.DIN_VALID  = din_valid_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.TIMEOUT    = timeout_q;
  assign bus.DOUT_READY = dout_ready_q;

endmodule

// File: tb/tb_scsi_initiator.sv
// Bench for scsi_initiator: behavioural target + host models, byte queues as reference.
module tb_scsi_initiator;
  localparam int SEL_TIMEOUT = 10740;
  localparam int ACK_SETTLE  = 4;
  localparam int RST_CYCLES  = 1075;
  localparam int LIM         = 200;
  localparam logic [2:0] PH_CMD  = 3'b101;
  localparam logic [2:0] PH_DOUT = 3'b111;
  localparam logic [2:0] PH_DIN  = 3'b110;
  localparam logic [2:0] PH_STAT = 3'b100;
  localparam logic [2:0] PH_MSGI = 3'b000;
  localparam logic [2:0] PH_BAD  = 3'b011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  scsi_initiator_if bus();

  scsi_initiator #(.SEL_TIMEOUT(SEL_TIMEOUT), .ACK_SETTLE(ACK_SETTLE), .RST_CYCLES(RST_CYCLES))
    dut (.CLK(clk), .RESET(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference data
  logic [7:0] cdb_ref [12];
  int         len_ref;
  logic [7:0] din_src [$];
  logic [7:0] din_q   [$];
  bit         stuck = 1'b0;

  // host-side models
  int din_mode = 0;   // 0 ready, 1 toggle every 3 cycles, 2 stalled
  int rdy_div  = 0;
  bit dout_en  = 1'b0;
  int dout_idx = 0;

  always @(negedge clk) begin
    case (din_mode)
      0: bus.DIN_READY = 1'b1;
      1: begin
        if (rdy_div == 2) begin rdy_div = 0; bus.DIN_READY = ~bus.DIN_READY; end
        else rdy_div++;
      end
      default: bus.DIN_READY = 1'b0;
    endcase
    if (bus.DIN_READY === 1'bx) bus.DIN_READY = 1'b0;
  end

  always @(negedge clk) begin
    if (dout_en) begin
      bus.DOUT_VALID = ($urandom_range(0, 2) != 0);
      bus.DOUT_DATA  = 8'hA0 + 8'(dout_idx);
    end else begin
      bus.DOUT_VALID = 1'b0;
      bus.DOUT_DATA  = 8'h00;
    end
  end

  // protocol monitor, sampled 1ns after the active edge
  int   cyc = 0, ack_fall_cnt = 0, done_cnt = 0, to_cnt = 0, dout_rdy_cnt = 0;
  int   dbo_stable = 0, t_busy = 0, t_to = 0, rst_low = 0, rst_len_last = 0;
  logic prev_ack = 1'b1, prev_busy = 1'b0, prev_rstn = 1'b1, prev_din_valid = 1'b0;
  logic [7:0] prev_dbo = 8'h00, prev_din_data = 8'h00;

  always @(posedge clk) begin
    #1;
    cyc++;
    dbo_stable = (bus.DBO === prev_dbo) ? dbo_stable + 1 : 0;
    if (prev_ack === 1'b1 && bus.ACK_N === 1'b0) begin
      ack_fall_cnt++;
      chk("ack_req", 32'(bus.REQ_N), 32'd0);
      chk("ack_settle", (dbo_stable >= ACK_SETTLE) ? ACK_SETTLE : dbo_stable, ACK_SETTLE);
    end
    if (prev_ack === 1'b0 && bus.ACK_N === 1'b0) chk("dbo_hold", 32'(bus.DBO), 32'(prev_dbo));
    if (bus.DIN_VALID === 1'b1) chk("ack_din", 32'(bus.ACK_N), 32'd1);
    if (prev_din_valid === 1'b1 && bus.DIN_READY === 1'b1) din_q.push_back(prev_din_data);
    if (bus.DONE === 1'b1) done_cnt++;
    if (bus.TIMEOUT === 1'b1) begin to_cnt++; t_to = cyc; end
    if (bus.DOUT_READY === 1'b1) begin dout_rdy_cnt++; dout_idx++; end
    if (prev_busy !== 1'b1 && bus.BUSY === 1'b1) t_busy = cyc;
    if (bus.RST_N === 1'b0) rst_low++;
    else if (prev_rstn === 1'b0) begin rst_len_last = rst_low; rst_low = 0; end
    prev_ack       = bus.ACK_N;
    prev_dbo       = bus.DBO;
    prev_busy      = bus.BUSY;
    prev_rstn      = bus.RST_N;
    prev_din_valid = bus.DIN_VALID;
    prev_din_data  = bus.DIN_DATA;
  end

  task automatic chk_reset_vals();
    chk("rst_sel_n", 32'(bus.SEL_N), 32'd1);
    chk("rst_ack_n", 32'(bus.ACK_N), 32'd1);
    chk("rst_rst_n", 32'(bus.RST_N), 32'd1);
    chk("rst_dbo", 32'(bus.DBO), 32'd0);
    chk("rst_status", 32'(bus.STATUS), 32'd0);
    chk("rst_message", 32'(bus.MESSAGE), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_done", 32'(bus.DONE), 32'd0);
    chk("rst_timeout", 32'(bus.TIMEOUT), 32'd0);
    chk("rst_din_valid", 32'(bus.DIN_VALID), 32'd0);
    chk("rst_dout_ready", 32'(bus.DOUT_READY), 32'd0);
  endtask

  task automatic issue_start();
    @(negedge clk);
    for (int i = 0; i < 12; i++) bus.CMD_BYTES[i*8 +: 8] = cdb_ref[i];
    bus.CMD_LEN = 4'(len_ref);
    bus.START   = 1'b1;
    @(negedge clk);
    bus.START   = 1'b0;
  endtask

  task automatic tgt_select();
    int n;
    n = 0;
    while (bus.SEL_N !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    chk("sel_lo", 32'(bus.SEL_N), 32'd0);
    if (bus.SEL_N !== 1'b0) begin stuck = 1'b1; return; end
    bus.BSY_N = 1'b0;
    n = 0;
    while (bus.SEL_N !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("sel_hi", 32'(bus.SEL_N), 32'd1);
  endtask

  task automatic tgt_xfer(input logic [2:0] ph, input logic [7:0] d, output logic [7:0] got);
    int n;
    got = 8'h00;
    if (stuck) return;
    @(negedge clk);
    {bus.MSG_N, bus.CD_N, bus.IO_N} = ph;
    bus.DBI   = d;
    bus.REQ_N = 1'b0;
    n = 0;
    while (bus.ACK_N !== 1'b0 && n < LIM) begin @(negedge clk); n++; end
    chk("ack_lo", 32'(bus.ACK_N), 32'd0);
    if (bus.ACK_N !== 1'b0) begin stuck = 1'b1; bus.REQ_N = 1'b1; return; end
    got       = bus.DBO;
    bus.REQ_N = 1'b1;
    n = 0;
    while (bus.ACK_N !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    chk("ack_hi", 32'(bus.ACK_N), 32'd1);
    if (bus.ACK_N !== 1'b1) stuck = 1'b1;
  endtask

  // command bytes from..to-1; beyond the CDB length the target must see 0x00
  task automatic tgt_cmd(input int from, input int to);
    logic [7:0] got;
    for (int i = from; i < to; i++) begin
      tgt_xfer(PH_CMD, 8'h00, got);
      chk("cmd_byte", 32'(got), (i < len_ref && i < 12) ? 32'(cdb_ref[i]) : 32'd0);
    end
  endtask

  task automatic tgt_din();
    logic [7:0] got;
    for (int i = 0; i < din_src.size(); i++) tgt_xfer(PH_DIN, din_src[i], got);
  endtask

  task automatic tgt_end(input logic [7:0] st, input logic [7:0] mg);
    logic [7:0] got;
    int n;
    tgt_xfer(PH_STAT, st, got);
    tgt_xfer(PH_MSGI, mg, got);
    @(negedge clk);
    bus.BSY_N = 1'b1;
    {bus.MSG_N, bus.CD_N, bus.IO_N} = 3'b111;
    n = 0;
    while (bus.BUSY !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    chk("busy_end", 32'(bus.BUSY), 32'd0);
  endtask

  task automatic din_cmp(input string tag);
    int errs, m;
    chk({tag, "_cnt"}, din_q.size(), din_src.size());
    errs = 0;
    m = (din_q.size() < din_src.size()) ? din_q.size() : din_src.size();
    for (int i = 0; i < m; i++) if (din_q[i] !== din_src[i]) errs++;
    chk({tag, "_data_errs"}, errs, 0);
  endtask

  task automatic run_tur(input string tag);
    int d0, a0;
    len_ref = 6;
    for (int i = 0; i < 12; i++) cdb_ref[i] = 8'h00;
    d0 = done_cnt; a0 = ack_fall_cnt;
    issue_start();
    tgt_select();
    tgt_cmd(0, 6);
    tgt_end(8'h00, 8'h00);
    repeat (2) @(negedge clk);
    // six command bytes plus the status and message bytes
    chk({tag, "_acks"}, ack_fall_cnt - a0, 8);
    chk({tag, "_status"}, 32'(bus.STATUS), 32'd0);
    chk({tag, "_message"}, 32'(bus.MESSAGE), 32'd0);
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
  endtask

  initial begin
    logic [7:0] got, st, mg;
    int d0, r0, t0, n, ncmd;
    bus.CMD_BYTES = '0; bus.CMD_LEN = 4'd0; bus.START = 1'b0; bus.BUS_RST = 1'b0;
    bus.DBI = 8'h00; bus.BSY_N = 1'b1; bus.REQ_N = 1'b1;
    bus.MSG_N = 1'b1; bus.CD_N = 1'b1; bus.IO_N = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals();

    run_tur("tur");

    // READ6 with 2048 DATA IN bytes, consumer toggling ready
    len_ref = 6;
    cdb_ref = '{8'h08, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00, 0, 0, 0, 0, 0, 0};
    din_src.delete(); din_q.delete();
    for (int i = 0; i < 2048; i++) din_src.push_back(8'(i));
    din_mode = 1;
    issue_start(); tgt_select(); tgt_cmd(0, 6); tgt_din(); tgt_end(8'h00, 8'h00);
    din_mode = 0;
    din_cmp("r6_din");

    // DATA OUT, 10 bytes with host valid gaps
    len_ref = 6;
    cdb_ref = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 0, 0, 0, 0, 0, 0};
    dout_idx = 0; r0 = dout_rdy_cnt; dout_en = 1'b1;
    issue_start(); tgt_select(); tgt_cmd(0, 6);
    for (int i = 0; i < 10; i++) begin
      tgt_xfer(PH_DOUT, 8'h00, got);
      chk("dout_byte", 32'(got), 32'(8'hA0 + 8'(i)));
    end
    dout_en = 1'b0;
    tgt_end(8'h00, 8'h00);
    chk("dout_ready_cnt", dout_rdy_cnt - r0, 10);

    // illegal phase and a second START during the transfer
    len_ref = 6;
    cdb_ref = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h5A, 0, 0, 0, 0, 0, 0};
    d0 = done_cnt;
    issue_start(); tgt_select(); tgt_cmd(0, 2);
    @(negedge clk);
    bus.CMD_BYTES = {96{1'b1}}; bus.CMD_LEN = 4'd1; bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (2) @(negedge clk);
    chk("start2_sel_n", 32'(bus.SEL_N), 32'd1);
    chk("start2_busy", 32'(bus.BUSY), 32'd1);
    tgt_cmd(2, 6);
    tgt_xfer(PH_BAD, 8'hC3, got);
    chk("bad_phase_dbo", 32'(got), 32'd0);
    tgt_end(8'h02, 8'h00);
    chk("bad_status", 32'(bus.STATUS), 32'h02);
    chk("bad_done", done_cnt - d0, 1);

    // randomized command lengths, DATA IN payloads, status and message
    for (int it = 0; it < 5; it++) begin
      len_ref = $urandom_range(1, 12);
      for (int i = 0; i < 12; i++) cdb_ref[i] = 8'($urandom);
      ncmd = len_ref + $urandom_range(0, 2);
      din_mode = $urandom_range(0, 1);
      din_src.delete(); din_q.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) din_src.push_back(8'($urandom));
      st = 8'($urandom); mg = 8'($urandom);
      d0 = done_cnt;
      issue_start(); tgt_select(); tgt_cmd(0, ncmd); tgt_din(); tgt_end(st, mg);
      din_cmp("rnd_din");
      chk("rnd_status", 32'(bus.STATUS), 32'(st));
      chk("rnd_message", 32'(bus.MESSAGE), 32'(mg));
      chk("rnd_done", done_cnt - d0, 1);
    end
    din_mode = 0;

    // selection timeout with BSY_N held high
    t0 = to_cnt;
    issue_start();
    repeat (3) @(negedge clk);
    chk("to_sel_lo", 32'(bus.SEL_N), 32'd0);
    n = 0;
    while (to_cnt == t0 && n < SEL_TIMEOUT + 200) begin @(negedge clk); n++; end
    chk("to_pulse", to_cnt - t0, 1);
    n = t_to - t_busy;
    chk("to_time", (n >= SEL_TIMEOUT - 1 && n <= SEL_TIMEOUT + 1) ? SEL_TIMEOUT : n, SEL_TIMEOUT);
    chk("to_sel_n", 32'(bus.SEL_N), 32'd1);
    chk("to_busy", 32'(bus.BUSY), 32'd0);

    // bus reset after 100 DATA IN bytes, with the 101st byte stalled
    len_ref = 6;
    cdb_ref = '{8'h08, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00, 0, 0, 0, 0, 0, 0};
    din_src.delete(); din_q.delete();
    for (int i = 0; i < 100; i++) din_src.push_back(8'(i * 7));
    issue_start(); tgt_select(); tgt_cmd(0, 6); tgt_din();
    din_mode = 2;
    @(negedge clk);
    {bus.MSG_N, bus.CD_N, bus.IO_N} = PH_DIN; bus.DBI = 8'h64; bus.REQ_N = 1'b0;
    repeat (3) @(negedge clk);
    chk("brst_din_pend", 32'(bus.DIN_VALID), 32'd1);
    d0 = done_cnt;
    bus.BUS_RST = 1'b1;
    @(negedge clk);
    bus.BUS_RST = 1'b0; bus.REQ_N = 1'b1; bus.BSY_N = 1'b1;
    {bus.MSG_N, bus.CD_N, bus.IO_N} = 3'b111;
    chk("brst_rst_n", 32'(bus.RST_N), 32'd0);
    chk("brst_ack_n", 32'(bus.ACK_N), 32'd1);
    chk("brst_din_valid", 32'(bus.DIN_VALID), 32'd0);
    chk("brst_busy", 32'(bus.BUSY), 32'd0);
    cdb_ref[0] = 8'h00;
    issue_start();
    repeat (2) @(negedge clk);
    chk("brst_start_ign", 32'(bus.BUSY), 32'd0);
    chk("brst_sel_n", 32'(bus.SEL_N), 32'd1);
    n = 0;
    while (bus.RST_N !== 1'b1 && n < RST_CYCLES + 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("brst_len", rst_len_last, RST_CYCLES);
    chk("brst_no_done", done_cnt - d0, 0);
    din_mode = 0;
    din_cmp("brst_din");
    run_tur("tur2");

    // RESET mid-transfer with a captured status and a pending DATA IN byte
    len_ref = 6;
    cdb_ref = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 0, 0, 0, 0, 0, 0};
    issue_start(); tgt_select(); tgt_cmd(0, 3);
    tgt_xfer(PH_STAT, 8'h7E, got);
    din_mode = 2;
    @(negedge clk);
    {bus.MSG_N, bus.CD_N, bus.IO_N} = PH_DIN; bus.DBI = 8'h55; bus.REQ_N = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_din_pend", 32'(bus.DIN_VALID), 32'd1);
    chk("mr_status", 32'(bus.STATUS), 32'h7E);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    bus.REQ_N = 1'b1; bus.BSY_N = 1'b1;
    {bus.MSG_N, bus.CD_N, bus.IO_N} = 3'b111;
    din_mode = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
